mem_bus_bridge: RTL and testbench

Bridges the picorv32 native memory interface to the on-chip word RAM and to a small I/O register window. Decodes each CPU request by address, sequences the RAM access with a configurable number of wait states, and waits on an I/O-side ready with a timeout. It returns read data and a single-cycle `mem_ready` to the CPU. Unmapped addresses, illegal byte strobes and I/O timeouts are reported through a sticky error flag.

---
 rtl/mem_bus_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Bridge from the picorv32 native memory interface to the on-chip word RAM and a small I/O window.
// Every output is registered; errors (unmapped, illegal strobe, I/O timeout) raise a sticky flag.
module mem_bus_bridge #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          IO_TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        ram_sel,
  output logic [3:0]  ram_wen,
  output logic [11:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_sel,
  output logic [3:0]  io_wen,
  output logic [7:0]  io_address,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ready,
  output logic        bus_error,
  output logic [31:0] err_addr
);

  typedef enum logic [2:0] {IDLE, RAM_ACC, IO_ACC, DONE, ERROR} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        ram_sel_q, ram_sel_d;
  logic [3:0]  ram_wen_q, ram_wen_d;
  logic [11:0] ram_address_q, ram_address_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        io_sel_q, io_sel_d;
  logic [3:0]  io_wen_q, io_wen_d;
  logic [7:0]  io_address_q, io_address_d;
  logic [31:0] io_wdata_q, io_wdata_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic ram_hit, io_hit, strb_ok;

  function automatic logic legal_strb(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: legal_strb = 1'b1;
      default:                            legal_strb = 1'b0;
    endcase
  endfunction

  assign ram_hit = (mem_addr[31:12] == RAM_BASE[31:12]);
  assign io_hit  = (mem_addr[31:8] == IO_BASE[31:8]);
  assign strb_ok = legal_strb(mem_wstrb);

  // Outputs are computed for the state being entered, so the registered copy lines up with it.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wstrb_d       = wstrb_q;
    cnt_d         = cnt_q;
    mem_ready_d   = 1'b0;
    mem_rdata_d   = '0;
    ram_sel_d     = 1'b0;
    ram_wen_d     = '0;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    io_sel_d      = 1'b0;
    io_wen_d      = '0;
    io_address_d  = io_address_q;
    io_wdata_d    = io_wdata_q;
    bus_error_d   = bus_error_q;
    err_addr_d    = err_addr_q;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wstrb_d = mem_wstrb;
          cnt_d   = '0;
          if (strb_ok && ram_hit) begin
            state_d       = RAM_ACC;
            ram_sel_d     = 1'b1;
            ram_address_d = {mem_addr[11:2], 2'b00};
            ram_wdata_d   = mem_wdata;
            ram_wen_d     = (WAIT_STATES == 0) ? mem_wstrb : 4'b0000;
          end else if (strb_ok && io_hit) begin
            state_d      = IO_ACC;
            io_sel_d     = 1'b1;
            io_wen_d     = mem_wstrb;
            io_address_d = mem_addr[7:0];
            io_wdata_d   = mem_wdata;
          end else begin
            state_d = ERROR;
          end
        end
      end

      // The write enable is raised only for the last access cycle so a write commits once.
      RAM_ACC: begin
        if (cnt_q == 8'(WAIT_STATES)) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
          mem_rdata_d = (wstrb_q == 4'b0000) ? ram_rdata : '0;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          ram_sel_d = 1'b1;
          if (WAIT_STATES != 0 && cnt_q == 8'(WAIT_STATES - 1))
            ram_wen_d = wstrb_q;
        end
      end

      // A ready seen on the last allowed cycle still completes the access normally.
      IO_ACC: begin
        if (io_ready) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
          mem_rdata_d = (wstrb_q == 4'b0000) ? io_rdata : '0;
        end else if (cnt_q == 8'(IO_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          io_sel_d = 1'b1;
          io_wen_d = wstrb_q;
        end
      end

      ERROR: begin
        state_d     = DONE;
        mem_ready_d = 1'b1;
        mem_rdata_d = ERR_DATA;
        bus_error_d = 1'b1;
        if (!bus_error_q)
          err_addr_d = addr_q;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wstrb_q       <= '0;
      cnt_q         <= '0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= '0;
      ram_sel_q     <= 1'b0;
      ram_wen_q     <= '0;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      io_sel_q      <= 1'b0;
      io_wen_q      <= '0;
      io_address_q  <= '0;
      io_wdata_q    <= '0;
      bus_error_q   <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wstrb_q       <= wstrb_d;
      cnt_q         <= cnt_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      ram_sel_q     <= ram_sel_d;
      ram_wen_q     <= ram_wen_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      io_sel_q      <= io_sel_d;
      io_wen_q      <= io_wen_d;
      io_address_q  <= io_address_d;
      io_wdata_q    <= io_wdata_d;
      bus_error_q   <= bus_error_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign ram_sel     = ram_sel_q;
  assign ram_wen     = ram_wen_q;
  assign ram_address = ram_address_q;
  assign ram_wdata   = ram_wdata_q;
  assign io_sel      = io_sel_q;
  assign io_wen      = io_wen_q;
  assign io_address  = io_address_q;
  assign io_wdata    = io_wdata_q;
  assign bus_error   = bus_error_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: three instances (0, 2 and 3 wait states) each with a RAM model.
// Only the instance under test receives mem_valid; address, data and I/O inputs are shared.
module tb_mem_bus_bridge;

  logic        clk;
  logic        resetn;
  logic        memValid [3];
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic [31:0] ioRdata;
  logic        ioReady;

  logic        memReady   [3];
  logic [31:0] memRdata   [3];
  logic        ramSel     [3];
  logic [3:0]  ramWen     [3];
  logic [11:0] ramAddress [3];
  logic [31:0] ramWdata   [3];
  logic [31:0] ramRdata   [3];
  logic        ioSel      [3];
  logic [3:0]  ioWen      [3];
  logic [7:0]  ioAddress  [3];
  logic [31:0] ioWdata    [3];
  logic        busError   [3];
  logic [31:0] errAddr    [3];
  logic [31:0] ramPeek    [3];

  logic        preWe;
  logic [9:0]  preAddr;
  logic [31:0] preData;
  logic [9:0]  peekAddr;

  int checks;
  int failures;

  // Observations gathered by runAccess for the calling test to compare.
  int          readyCycle;
  logic [31:0] rdataSeen;
  logic        readyAfter;
  int          obsRamSel;
  logic [11:0] obsRamAddr;
  int          obsWenCount;
  int          obsWenCycle;
  logic [3:0]  obsWenVal;
  int          obsIoSel;
  logic [7:0]  obsIoAddr;
  logic [3:0]  obsIoWen;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic [31:0] ram [1024];

    mem_bus_bridge #(.WAIT_STATES(W)) u_dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(memValid[g]), .mem_ready(memReady[g]),
      .mem_addr(memAddr), .mem_wdata(memWdata), .mem_wstrb(memWstrb),
      .mem_rdata(memRdata[g]),
      .ram_sel(ramSel[g]), .ram_wen(ramWen[g]), .ram_address(ramAddress[g]),
      .ram_wdata(ramWdata[g]), .ram_rdata(ramRdata[g]),
      .io_sel(ioSel[g]), .io_wen(ioWen[g]), .io_address(ioAddress[g]),
      .io_wdata(ioWdata[g]), .io_rdata(ioRdata), .io_ready(ioReady),
      .bus_error(busError[g]), .err_addr(errAddr[g])
    );

    assign ramRdata[g] = ram[ramAddress[g][11:2]];
    assign ramPeek[g]  = ram[peekAddr];

    // Byte-lane RAM model; the preload port lets the bench seed known words.
    always @(posedge clk) begin
      if (preWe)
        ram[preAddr] <= preData;
      else
        for (int b = 0; b < 4; b++)
          if (ramSel[g] && ramWen[g][b])
            ram[ramAddress[g][11:2]][8*b +: 8] <= ramWdata[g][8*b +: 8];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [159:0] allOut(input int d);
    allOut = {memReady[d], memRdata[d], ramSel[d], ramWen[d], ramAddress[d], ramWdata[d],
              ioSel[d], ioWen[d], ioAddress[d], ioWdata[d], busError[d], errAddr[d]};
  endfunction

  // Preload one RAM word in all three models; called and returns at a falling edge.
  task automatic loadRam(input logic [9:0] word, input logic [31:0] data);
    preWe = 1'b1; preAddr = word; preData = data;
    @(negedge clk);
    preWe = 1'b0;
  endtask

  // Issues one request at the current falling edge (cycle 0) and observes cycles 1..N.
  // ioReadyAt = n raises io_ready on the n-th io_sel cycle; 0 means never.
  task automatic runAccess(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int ioReadyAt);
    memValid[d] = 1'b1; memAddr = addr; memWdata = wdata; memWstrb = strb; ioReady = 1'b0;
    readyCycle = -1; rdataSeen = '0;
    obsRamSel = 0; obsRamAddr = '0; obsWenCount = 0; obsWenCycle = 0; obsWenVal = '0;
    obsIoSel = 0; obsIoAddr = '0; obsIoWen = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) memValid[d] = 1'b0;
      if (ramSel[d]) begin
        obsRamSel++;
        if (obsRamSel == 1) obsRamAddr = ramAddress[d];
      end
      if (ramWen[d] != 4'b0000) begin
        obsWenCount++; obsWenCycle = k; obsWenVal = ramWen[d];
      end
      if (ioSel[d]) begin
        obsIoSel++; obsIoAddr = ioAddress[d]; obsIoWen = ioWen[d];
      end
      ioReady = ioSel[d] && (ioReadyAt != 0) && (obsIoSel == ioReadyAt);
      if (memReady[d]) begin
        readyCycle = k; rdataSeen = memRdata[d];
        break;
      end
    end
    ioReady = 1'b0;
    @(negedge clk);
    readyAfter = memReady[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (allOut(d) !== '0) begin
        failures++; $display("FAIL reset_outputs dut%0d: got %h expected 0", d, allOut(d));
      end
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_read();
    loadRam(10'd4, 32'h1234_5678);
    runAccess(0, 32'h0000_0010, 32'h0, 4'b0000, 0);
    checks++; if (readyCycle != 2) begin failures++; $display("FAIL read_latency: got %0d expected 2", readyCycle); end
    checks++; if (rdataSeen !== 32'h1234_5678) begin failures++; $display("FAIL read_data: got %h expected 12345678", rdataSeen); end
    checks++; if (obsRamSel != 1) begin failures++; $display("FAIL read_sel_cycles: got %0d expected 1", obsRamSel); end
    checks++; if (obsWenCount != 0) begin failures++; $display("FAIL read_no_wen: got %0d expected 0", obsWenCount); end
    checks++; if (readyAfter !== 1'b0) begin failures++; $display("FAIL read_ready_pulse: got %b expected 0", readyAfter); end
    runAccess(0, 32'h0000_0013, 32'h0, 4'b0000, 0);
    checks++; if (obsRamAddr !== 12'h010) begin failures++; $display("FAIL read_addr_align: got %h expected 010", obsRamAddr); end
    checks++; if (rdataSeen !== 32'h1234_5678) begin failures++; $display("FAIL read_unaligned_data: got %h expected 12345678", rdataSeen); end
  endtask

  task automatic test_ram_write();
    loadRam(10'd8, 32'h1122_3344);
    runAccess(1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0100, 0);
    checks++; if (obsWenCount != 1 || obsWenCycle != 3) begin failures++; $display("FAIL write_wen_cycle: got count %0d cycle %0d expected 1 at 3", obsWenCount, obsWenCycle); end
    checks++; if (obsWenVal !== 4'b0100) begin failures++; $display("FAIL write_wen_value: got %b expected 0100", obsWenVal); end
    checks++; if (readyCycle != 4) begin failures++; $display("FAIL write_latency: got %0d expected 4", readyCycle); end
    checks++; if (rdataSeen !== 32'h0) begin failures++; $display("FAIL write_rdata: got %h expected 0", rdataSeen); end
    checks++; if (obsRamSel != 3) begin failures++; $display("FAIL write_sel_cycles: got %0d expected 3", obsRamSel); end
    runAccess(1, 32'h0000_0020, 32'h0, 4'b0000, 0);
    checks++; if (rdataSeen !== 32'h11BB_3344) begin failures++; $display("FAIL write_readback: got %h expected 11bb3344", rdataSeen); end
    checks++; if (readyCycle != 4) begin failures++; $display("FAIL readback_latency: got %0d expected 4", readyCycle); end
  endtask

  task automatic test_back_to_back();
    runAccess(1, 32'h0000_0020, 32'h0, 4'b0000, 0);
    runAccess(1, 32'h0000_0020, 32'h5566_7788, 4'b0011, 0);
    checks++; if (readyCycle != 4 || readyAfter !== 1'b0) begin failures++; $display("FAIL b2b_write: got cycle %0d after %b expected 4 0", readyCycle, readyAfter); end
    runAccess(1, 32'h0000_0020, 32'h0, 4'b0000, 0);
    checks++; if (rdataSeen !== 32'h11BB_7788) begin failures++; $display("FAIL b2b_readback: got %h expected 11bb7788", rdataSeen); end
  endtask

  task automatic test_io();
    ioRdata = 32'h0000_00A5;
    runAccess(0, 32'h8000_0004, 32'h0, 4'b0000, 3);
    checks++; if (readyCycle != 4) begin failures++; $display("FAIL io_read_latency: got %0d expected 4", readyCycle); end
    checks++; if (rdataSeen !== 32'h0000_00A5) begin failures++; $display("FAIL io_read_data: got %h expected 000000a5", rdataSeen); end
    checks++; if (obsIoSel != 3 || obsIoAddr !== 8'h04) begin failures++; $display("FAIL io_read_sel: got %0d cycles addr %h expected 3 04", obsIoSel, obsIoAddr); end
    runAccess(0, 32'h8000_0010, 32'h0000_BEEF, 4'b0011, 15);
    checks++; if (readyCycle != 16) begin failures++; $display("FAIL io_ready_at_limit: got %0d expected 16", readyCycle); end
    checks++; if (obsIoWen !== 4'b0011 || rdataSeen !== 32'h0) begin failures++; $display("FAIL io_write_wen: got %b data %h expected 0011 0", obsIoWen, rdataSeen); end
    checks++; if (busError[0] !== 1'b0) begin failures++; $display("FAIL io_limit_no_error: got %b expected 0", busError[0]); end
  endtask

  task automatic test_io_timeout();
    runAccess(0, 32'h8000_0008, 32'h1234_0000, 4'b1111, 0);
    checks++; if (readyCycle != 17) begin failures++; $display("FAIL timeout_latency: got %0d expected 17", readyCycle); end
    checks++; if (rdataSeen !== 32'hDEAD_BEEF) begin failures++; $display("FAIL timeout_data: got %h expected deadbeef", rdataSeen); end
    checks++; if (obsIoSel != 15) begin failures++; $display("FAIL timeout_sel_cycles: got %0d expected 15", obsIoSel); end
    checks++; if (busError[0] !== 1'b1 || errAddr[0] !== 32'h8000_0008) begin failures++; $display("FAIL timeout_err: got %b %h expected 1 80000008", busError[0], errAddr[0]); end
  endtask

  task automatic test_decode_errors();
    loadRam(10'd12, 32'hCAFE_F00D);
    runAccess(0, 32'h4000_0000, 32'h0, 4'b0000, 0);
    checks++; if (readyCycle != 2 || rdataSeen !== 32'hDEAD_BEEF) begin failures++; $display("FAIL unmapped_resp: got cycle %0d data %h expected 2 deadbeef", readyCycle, rdataSeen); end
    checks++; if (obsRamSel != 0 || obsIoSel != 0) begin failures++; $display("FAIL unmapped_sel: got %0d %0d expected 0 0", obsRamSel, obsIoSel); end
    runAccess(0, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0110, 0);
    checks++; if (readyCycle != 2 || rdataSeen !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bad_strobe_resp: got cycle %0d data %h expected 2 deadbeef", readyCycle, rdataSeen); end
    checks++; if (obsRamSel != 0 || obsWenCount != 0) begin failures++; $display("FAIL bad_strobe_sel: got %0d %0d expected 0 0", obsRamSel, obsWenCount); end
    peekAddr = 10'd12; #1;
    checks++; if (ramPeek[0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL bad_strobe_ram: got %h expected cafef00d", ramPeek[0]); end
    checks++; if (errAddr[0] !== 32'h8000_0008 || busError[0] !== 1'b1) begin failures++; $display("FAIL err_addr_sticky: got %h %b expected 80000008 1", errAddr[0], busError[0]); end
  endtask

  task automatic test_reset_mid();
    loadRam(10'd16, 32'h0102_0304);
    memValid[2] = 1'b1; memAddr = 32'h0000_0040; memWdata = 32'hFFFF_FFFF; memWstrb = 4'b1111;
    @(negedge clk);
    memValid[2] = 1'b0;
    checks++; if (ramSel[2] !== 1'b1) begin failures++; $display("FAIL mid_reset_started: got %b expected 1", ramSel[2]); end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (allOut(2) !== '0) begin failures++; $display("FAIL mid_reset_outputs: got %h expected 0", allOut(2)); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    peekAddr = 10'd16; #1;
    checks++; if (ramPeek[2] !== 32'h0102_0304) begin failures++; $display("FAIL mid_reset_ram: got %h expected 01020304", ramPeek[2]); end
    checks++; if (busError[0] !== 1'b0 || errAddr[0] !== 32'h0) begin failures++; $display("FAIL reset_clears_error: got %b %h expected 0 0", busError[0], errAddr[0]); end
    @(negedge clk);
    runAccess(2, 32'h0000_0040, 32'h0, 4'b0000, 0);
    checks++; if (readyCycle != 5 || rdataSeen !== 32'h0102_0304) begin failures++; $display("FAIL post_reset_read: got cycle %0d data %h expected 5 01020304", readyCycle, rdataSeen); end
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    for (int d = 0; d < 3; d++) memValid[d] = 1'b0;
    memAddr = '0; memWdata = '0; memWstrb = '0;
    ioRdata = '0; ioReady = 1'b0;
    preWe = 1'b0; preAddr = '0; preData = '0; peekAddr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ram_read();
    test_ram_write();
    test_back_to_back();
    test_io();
    test_io_timeout();
    test_decode_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
